// File: rtl/opb_register_bank_s2p.sv
// OPB slave register bank: snapshots a wide fabric word set on a strobe
// and exposes it with status/control over a single-cycle OPB handshake.
module opb_register_bank_s2p #(
  parameter logic [31:0] C_BASEADDR   = 32'h01001200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010012FF,
  parameter int          C_NUM_REGS   = 4,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]    OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]      OPB_DBus,
  input  logic                         OPB_RNW,
  input  logic                         OPB_select,
  input  logic                         OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]      Sl_DBus,
  output logic                         Sl_xferAck,
  output logic                         Sl_errAck,
  output logic                         Sl_retry,
  output logic                         Sl_toutSup,
  input  logic [C_NUM_REGS*32-1:0]     user_data_in,
  input  logic                         user_valid
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        ack;

  logic [31:0] addr;
  logic [31:0] offset;
  logic [29:0] word;
  logic [31:0] wdat;
  logic [31:0] rd_val;
  logic [31:0] rd_data;

  logic        in_range;
  logic        hit;
  logic        ctrl_wr;
  logic        clr;
  logic        cap;

  logic [31:0] shadow [C_NUM_REGS];
  logic [15:0] seq_cnt;
  logic        new_data;
  logic        overflow;
  logic        freeze;

  assign addr     = {OPB_ABus[0:C_OPB_AWIDTH-3], 2'b00};
  assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign hit      = (state == IDLE) && OPB_select && in_range;
  assign offset   = addr - C_BASEADDR;
  assign word     = offset[31:2];
  assign wdat     = OPB_DBus;

  assign ctrl_wr  = hit && !OPB_RNW &&
                    (word == 30'd1) &&
                    OPB_BE[C_OPB_DWIDTH/8-1];
  assign clr      = ctrl_wr && wdat[1];
  assign cap      = user_valid && !freeze;

  always_comb begin
    rd_val = '0;
    if (word == 30'd0)
      rd_val = {seq_cnt, 8'(C_NUM_REGS),
                6'd0, overflow, new_data};
    else if (word == 30'd1)
      rd_val = {31'd0, freeze};
    for (int k = 0; k < C_NUM_REGS; k++)
      if (word == 30'(k + 2))
        rd_val = shadow[k];
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    unique case (state)
      IDLE: if (hit) state_nxt = ACK;
      ACK: begin
        state_nxt = IDLE;
        ack       = 1'b1;
      end
    endcase
  end

  // A capture on the same edge as a clear wins; the clear
  // only suppresses the overflow the capture would raise.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      rd_data  <= '0;
      seq_cnt  <= '0;
      new_data <= 1'b0;
      overflow <= 1'b0;
      freeze   <= 1'b0;
      for (int k = 0; k < C_NUM_REGS; k++)
        shadow[k] <= '0;
    end else begin
      if (hit)
        rd_data <= OPB_RNW ? rd_val : '0;
      if (ctrl_wr)
        freeze <= wdat[0];
      if (cap) begin
        for (int k = 0; k < C_NUM_REGS; k++)
          shadow[k] <= user_data_in[32*k +: 32];
        seq_cnt  <= seq_cnt + 16'd1;
        new_data <= 1'b1;
        overflow <= !clr && (overflow || new_data);
      end else if (clr) begin
        new_data <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

  assign Sl_xferAck = ack;
  assign Sl_DBus    = ack ? rd_data : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr,
                       OPB_ABus[C_OPB_AWIDTH-2:C_OPB_AWIDTH-1],
                       offset[1:0],
                       OPB_BE[0:C_OPB_DWIDTH/8-2],
                       wdat[31:2],
                       ($bits(C_FAMILY) > 0)};

endmodule

// File: tb/tb_opb_register_bank_s2p.sv
// Bench for opb_register_bank_s2p: directed map/handshake checks
// plus a randomized run compared every cycle against a reference model.
module tb_opb_register_bank_s2p;

  localparam logic [31:0] BASE = 32'h01001200;
  localparam logic [31:0] HIGH = 32'h010012FF;
  localparam int          NR   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       abus = '0;
  logic [0:3]        be = '0;
  logic [31:0]       wd = '0;
  logic              rnw = 1'b1;
  logic              sel = 1'b0;
  logic              seqa = 1'b0;
  logic [31:0]       sdbus;
  logic              ack;
  logic              erra;
  logic              retry;
  logic              tout;
  logic [NR*32-1:0]  udata = '0;
  logic              uv = 1'b0;

  opb_register_bank_s2p #(
    .C_BASEADDR  (BASE),
    .C_HIGHADDR  (HIGH),
    .C_NUM_REGS  (NR),
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_FAMILY    ("virtex5")
  ) dut (
    .OPB_Clk     (clk),
    .OPB_Rst     (rst),
    .OPB_ABus    (abus),
    .OPB_BE      (be),
    .OPB_DBus    (wd),
    .OPB_RNW     (rnw),
    .OPB_select  (sel),
    .OPB_seqAddr (seqa),
    .Sl_DBus     (sdbus),
    .Sl_xferAck  (ack),
    .Sl_errAck   (erra),
    .Sl_retry    (retry),
    .Sl_toutSup  (tout),
    .user_data_in(udata),
    .user_valid  (uv)
  );

  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;

  bit [31:0] msh [NR];
  bit [15:0] mseq;
  bit        mnd, mov, mfrz;
  bit        exp_ack;
  bit [31:0] exp_dbus;
  bit        m_hit, m_clr, m_cap, m_nfrz;
  bit [31:0] m_rv, m_word;

  function automatic bit in_map(logic [31:0] a);
    logic [31:0] am;
    am = a & ~32'h3;
    return (am >= BASE) && (am <= HIGH);
  endfunction

  function automatic bit [31:0] word_of(logic [31:0] a);
    return ((a & ~32'h3) - BASE) >> 2;
  endfunction

  function automatic bit [31:0] model_read(logic [31:0] a);
    bit [31:0] w;
    w = word_of(a);
    if (w == 0) return {mseq, 8'(NR), 6'd0, mov, mnd};
    if (w == 1) return {31'd0, mfrz};
    if (w >= 2 && w < 2 + NR) return msh[w-2];
    return 32'd0;
  endfunction

  // Reference: an access is accepted on any edge where select hits the
  // decoded range and no ack is being given; its ack/data follow one cycle later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NR; k++) msh[k] = 0;
      mseq = 0; mnd = 0; mov = 0; mfrz = 0;
      exp_ack = 0; exp_dbus = 0;
    end else begin
      m_hit  = !exp_ack && sel && in_map(abus);
      m_rv   = model_read(abus);
      m_word = word_of(abus);
      m_clr  = 0;
      m_nfrz = mfrz;
      if (m_hit && !rnw && m_word == 1 && be[3]) begin
        m_nfrz = wd[0];
        m_clr  = wd[1];
      end
      m_cap = uv && !mfrz;
      if (m_cap) begin
        for (int k = 0; k < NR; k++) msh[k] = udata[32*k +: 32];
        mseq = mseq + 1;
        mov  = !m_clr && (mov || mnd);
        mnd  = 1;
      end else if (m_clr) begin
        mnd = 0;
        mov = 0;
      end
      mfrz     = m_nfrz;
      exp_ack  = m_hit;
      exp_dbus = (m_hit && rnw) ? m_rv : 32'd0;
    end
  end

  always @(negedge clk) begin
    ncomp++;
    if (ack !== exp_ack || sdbus !== exp_dbus ||
        erra !== 1'b0 || retry !== 1'b0 || tout !== 1'b0) begin
      nfail++;
      $display("FAIL cycle t=%0t: ack=%b dbus=%h err/retry/tout=%b%b%b, required ack=%b dbus=%h 000",
               $time, ack, sdbus, erra, retry, tout, exp_ack, exp_dbus);
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    ncomp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input bit r,
                     input logic [31:0] d, input logic [0:3] b,
                     output logic [31:0] rd, output logic ak);
    sel = 1; abus = a; rnw = r; wd = d; be = b;
    @(negedge clk);
    rd = sdbus; ak = ack;
    sel = 0; rnw = 1;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] rd;
    logic        ak;
    bus(a, 1, 0, 4'hF, rd, ak);
    check({name, " ack"}, {31'd0, ak}, 32'd1);
    check(name, rd, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [0:3] b);
    logic [31:0] rd;
    logic        ak;
    bus(a, 0, d, b, rd, ak);
  endtask

  task automatic capture(input logic [NR*32-1:0] v);
    udata = v; uv = 1;
    @(negedge clk);
    uv = 0;
  endtask

  logic [5:0]  pat;
  logic [31:0] rd;
  logic        ak;
  int          n;

  initial begin
    repeat (3) @(negedge clk);
    check("reset ack", {31'd0, ack}, 32'd0);
    check("reset dbus", sdbus, 32'd0);
    rst = 0;
    @(negedge clk);

    rd_chk("status after reset", BASE, 32'h00000400);

    capture({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    rd_chk("data0", BASE + 32'h08, 32'h11111111);
    rd_chk("data1", BASE + 32'h0C, 32'h22222222);
    rd_chk("data2", BASE + 32'h10, 32'h33333333);
    rd_chk("data3", BASE + 32'h14, 32'h44444444);
    rd_chk("status one capture", BASE, 32'h00010401);

    capture({4{32'h55555555}});
    capture({4{32'h66666666}});
    rd_chk("status overflow", BASE, 32'h00030403);
    wr(BASE + 4, 32'h2, 4'hF);
    rd_chk("status cleared", BASE, 32'h00030400);

    wr(BASE + 4, 32'h1, 4'hF);
    rd_chk("control frozen", BASE + 4, 32'h1);
    capture({4{32'hA0A0A0A0}});
    rd_chk("data0 frozen", BASE + 8, 32'h66666666);
    rd_chk("status frozen", BASE, 32'h00030400);
    wr(BASE + 4, 32'h0, 4'hF);
    capture({4{32'hA0A0A0A0}});
    rd_chk("data0 unfrozen", BASE + 8, 32'hA0A0A0A0);
    rd_chk("status unfrozen", BASE, 32'h00040401);

    sel = 1; abus = BASE + 4; rnw = 1; be = 4'hF;
    for (int i = 0; i < 6; i++) begin
      pat[5-i] = ack;
      @(negedge clk);
    end
    sel = 0;
    check("held select pattern", {26'd0, pat}, 32'h15);

    bus(HIGH + 4, 1, 0, 4'hF, rd, ak);
    check("out of range ack", {31'd0, ak}, 32'd0);
    rd_chk("offset f0 reads 0", BASE + 32'hF0, 32'h0);
    rd_chk("low addr bits ignored", BASE + 32'h0B, 32'hA0A0A0A0);
    wr(BASE + 8, 32'hFFFFFFFF, 4'hF);
    wr(BASE, 32'hFFFFFFFF, 4'hF);
    rd_chk("data write ignored", BASE + 8, 32'hA0A0A0A0);
    wr(BASE + 4, 32'h1, 4'b1110);
    rd_chk("ctrl be3=0 ignored", BASE + 4, 32'h0);

    sel = 1; abus = BASE + 4; rnw = 0; wd = 32'h2; be = 4'hF;
    udata = {4{32'h0BADF00D}}; uv = 1;
    @(negedge clk);
    sel = 0; rnw = 1; uv = 0;
    @(negedge clk);
    rd_chk("capture beats clear", BASE, 32'h00050401);
    capture({4{32'h12345678}});
    rd_chk("status overflow again", BASE, 32'h00060403);

    sel = 1; abus = BASE; rnw = 1; be = 4'hF;
    udata = {4{32'h87654321}}; uv = 1;
    @(negedge clk);
    check("status pre-capture", sdbus, 32'h00060403);
    sel = 0; uv = 0;
    @(negedge clk);
    rd_chk("status post-capture", BASE, 32'h00070403);

    sel = 1; abus = BASE + 4; rnw = 0; wd = 32'h3; be = 4'hF;
    udata = {4{32'hCAFEF00D}}; uv = 1;
    @(negedge clk);
    sel = 0; rnw = 1;
    @(negedge clk);
    uv = 0;
    rd_chk("freeze edge capture", BASE, 32'h00080401);
    rd_chk("freeze edge data", BASE + 8, 32'hCAFEF00D);
    wr(BASE + 4, 32'h0, 4'hF);

    for (int i = 0; i < 3000; i++) begin
      sel = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: abus = BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
        5: abus = BASE + 32'hF0;
        6: abus = HIGH;
        7: abus = HIGH + 1;
        8: abus = HIGH + 4;
        default: abus = BASE - 4;
      endcase
      rnw = ($urandom_range(0, 1) == 1);
      be = 4'($urandom);
      wd = $urandom;
      wd[0] = ($urandom_range(0, 3) == 0);
      uv = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < NR; k++) udata[32*k +: 32] = $urandom;
      @(negedge clk);
    end
    sel = 0; uv = 0; rnw = 1;
    @(negedge clk);
    @(negedge clk);

    wr(BASE + 4, 32'h2, 4'hF);
    n = 32'hFFFF - 32'(mseq);
    uv = 1;
    repeat (n) @(negedge clk);
    uv = 0;
    bus(BASE, 1, 0, 4'hF, rd, ak);
    check("seq at ffff", {16'd0, rd[31:16]}, 32'hFFFF);
    capture({4{32'h0F0F0F0F}});
    bus(BASE, 1, 0, 4'hF, rd, ak);
    check("seq wraps", {16'd0, rd[31:16]}, 32'h0);

    sel = 1; abus = BASE; rnw = 1; be = 4'hF;
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("reset mid-ack", {31'd0, ack}, 32'd0);
    check("reset mid-ack dbus", sdbus, 32'd0);
    sel = 0;
    @(negedge clk);
    rst = 0;
    rd_chk("status after reset mid-access", BASE, 32'h00000400);
    rd_chk("data0 after reset", BASE + 8, 32'h0);
    rd_chk("ctrl after reset", BASE + 4, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
